// File: rtl/fc_irq_ctrl_if.sv
// APB slave bus bundle for the FC interrupt controller.
// The master drives address, control and write data. The slave returns read data and status.
interface fc_irq_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fc_irq_ctrl.sv
// Fabric-controller interrupt controller: edge-detected pending lines, mask, fixed-priority
// request to the core, event-ID FIFO on a dedicated line, zero-wait-state APB register access.
module fc_irq_ctrl #(
    parameter int NB_IRQ         = 32,
    parameter int EVENT_ID_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_IRQ_LINE  = 26,
    parameter int ONEHOT_MODE    = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_IRQ-1:0]         events_i,
    input  logic                      event_fifo_valid_i,
    input  logic [EVENT_ID_WIDTH-1:0] event_fifo_data_i,
    output logic                      event_fifo_fulln_o,
    output logic                      irq_req_o,
    output logic [$clog2(NB_IRQ)-1:0] irq_id_o,
    output logic [NB_IRQ-1:0]         irq_x_o,
    input  logic                      irq_ack_i,
    input  logic [$clog2(NB_IRQ)-1:0] irq_ack_id_i,
    fc_irq_ctrl_if.slave              apb
);
    localparam int ID_W  = $clog2(NB_IRQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        ADDR_MASK  = 4'h0,
        ADDR_PEND  = 4'h4,
        ADDR_CLEAR = 4'h8,
        ADDR_EVENT = 4'hC
    } reg_addr_e;

    logic [NB_IRQ-1:0]         ev_prev_q, pend_q, pend_d, mask_q;
    logic [NB_IRQ-1:0]         rise, ack_vec, set_vec, clr_vec, cand, wdata_v;
    logic                      first_q;
    logic                      irq_req_q, irq_req_d;
    logic [ID_W-1:0]           irq_id_q, irq_id_d;
    logic [EVENT_ID_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wptr_q, rptr_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      access, wr_en, rd_en, push, pop;
    logic [31:0]               rdata;

    assign access  = apb.psel & apb.penable;
    assign wr_en   = access & apb.pwrite;
    assign rd_en   = access & ~apb.pwrite;
    assign wdata_v = apb.pwdata[NB_IRQ-1:0];

    // A pop in the same cycle frees the slot, so a push is still taken when the FIFO is full.
    assign pop  = rd_en && (apb.paddr == ADDR_EVENT) && (cnt_q != '0);
    assign push = event_fifo_valid_i && ((cnt_q != DEPTH_C) || pop);
    assign event_fifo_fulln_o = (cnt_q != DEPTH_C);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Edges are masked during the first cycle after reset, so lines that are already high are not counted.
    assign rise = events_i & ~ev_prev_q & {NB_IRQ{~first_q}};

    always_comb begin
        ack_vec = '0;
        if (irq_ack_i && (32'(irq_ack_id_i) < NB_IRQ)) begin
            ack_vec[irq_ack_id_i] = 1'b1;
        end
        set_vec = rise | ((wr_en && apb.paddr == ADDR_PEND) ? wdata_v : '0);
        clr_vec = ack_vec | ((wr_en && apb.paddr == ADDR_CLEAR) ? wdata_v : '0);
        pend_d  = (pend_q & ~clr_vec) | set_vec;
        // The FIFO line shows FIFO occupancy. Edges, set, clear and ack do not change it.
        pend_d[FIFO_IRQ_LINE] = (cnt_d != '0);
    end

    assign cand = pend_q & mask_q;

    always_comb begin
        irq_req_d = 1'b0;
        irq_id_d  = '0;
        for (int k = NB_IRQ - 1; k >= 0; k--) begin
            if (cand[k]) begin
                irq_req_d = 1'b1;
                irq_id_d  = ID_W'(k);
            end
        end
    end

    assign irq_req_o = irq_req_q;
    assign irq_id_o  = irq_id_q;

    always_comb begin
        irq_x_o = '0;
        if (ONEHOT_MODE != 0 && irq_req_q) begin
            irq_x_o = NB_IRQ'(1) << irq_id_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (apb.paddr)
                ADDR_MASK:  rdata = 32'(mask_q);
                ADDR_PEND:  rdata = 32'(pend_q);
                ADDR_EVENT: rdata = (cnt_q != '0) ? 32'(fifo_mem[rptr_q]) : '0;
                default:    rdata = '0;
            endcase
        end
    end

    assign apb.prdata  = rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = access & (apb.paddr[1:0] != 2'b00);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ev_prev_q <= '0;
            first_q   <= 1'b1;
            pend_q    <= '0;
            mask_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            ev_prev_q <= events_i;
            first_q   <= 1'b0;
            pend_q    <= pend_d;
            if (wr_en && apb.paddr == ADDR_MASK) mask_q <= wdata_v;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            cnt_q     <= cnt_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
        end
    end

    // NOTE: the FIFO storage is not reset. The count and pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q] <= event_fifo_data_i;
    end
endmodule

// File: tb/tb_fc_irq_ctrl.sv
// Randomised, scoreboard-checked bench for fc_irq_ctrl. It compares against a behavioural model
// of pending bits, mask, arbitration and the event FIFO.
module tb_fc_irq_ctrl;
    localparam int NB    = 32;
    localparam int DEPTH = 4;
    localparam int LINE  = 26;

    typedef struct {
        logic        req;
        logic [4:0]  id;
        logic [31:0] x;
        logic        fulln;
        logic        pslverr;
        logic [31:0] prdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] events;
    logic        fv;
    logic [7:0]  fd;
    logic        fulln;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic [31:0] irq_x;
    logic        ack;
    logic [4:0]  ack_id;

    fc_irq_ctrl_if apb_bus ();

    fc_irq_ctrl #(
        .NB_IRQ(NB), .EVENT_ID_WIDTH(8), .FIFO_DEPTH(DEPTH),
        .FIFO_IRQ_LINE(LINE), .ONEHOT_MODE(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .events_i(events),
        .event_fifo_valid_i(fv), .event_fifo_data_i(fd), .event_fifo_fulln_o(fulln),
        .irq_req_o(irq_req), .irq_id_o(irq_id), .irq_x_o(irq_x),
        .irq_ack_i(ack), .irq_ack_id_i(ack_id), .apb(apb_bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Drive values for the next cycle.
    logic        d_rst = 1'b0, d_fv = 1'b0, d_ack = 1'b0;
    logic        d_psel = 1'b0, d_pen = 1'b0, d_pwr = 1'b0;
    logic [31:0] d_ev = '0, d_wdata = '0;
    logic [7:0]  d_fd = '0;
    logic [4:0]  d_ack_id = '0;
    logic [3:0]  d_addr = '0;

    // Behavioural model state.
    logic [31:0] m_pend = '0, m_mask = '0, m_prev = '0;
    logic [7:0]  m_fifo [$];
    bit          m_first = 1'b0, m_req = 1'b0, m_valid = 1'b0;
    int          m_id = 0;
    exp_t        exp_q [$];
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit acc, pop, push, rise, set, clr;
        acc = d_psel && d_pen;
        if (m_valid) begin
            e.req     = m_req;
            e.id      = m_req ? 5'(m_id) : 5'd0;
            e.x       = m_req ? (32'd1 << m_id) : 32'd0;
            e.fulln   = (m_fifo.size() != DEPTH);
            e.pslverr = acc && (d_addr % 4 != 0);
            e.prdata  = 32'd0;
            if (acc && !d_pwr) begin
                if (d_addr == 4'd0)       e.prdata = m_mask;
                else if (d_addr == 4'd4)  e.prdata = m_pend;
                else if (d_addr == 4'd12) e.prdata = (m_fifo.size() > 0) ? {24'd0, m_fifo[0]} : 32'd0;
            end
            exp_q.push_back(e);
        end
        if (d_rst) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_fifo.delete();
            m_req = 1'b0; m_id = 0; m_first = 1'b1; m_valid = 1'b1;
            return;
        end
        // The request visible next cycle is the lowest set line of this cycle's pending & mask.
        m_req = 1'b0;
        m_id  = 0;
        for (int k = 0; k < NB; k++) begin
            if (m_pend[k] && m_mask[k]) begin
                m_req = 1'b1;
                m_id  = k;
                break;
            end
        end
        pop  = acc && !d_pwr && d_addr == 4'd12 && m_fifo.size() > 0;
        push = d_fv && (m_fifo.size() < DEPTH || pop);
        if (pop)  void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(d_fd);
        for (int k = 0; k < NB; k++) begin
            if (k == LINE) continue;
            rise = d_ev[k] && !m_prev[k] && !m_first;
            set  = rise || (acc && d_pwr && d_addr == 4'd4 && d_wdata[k]);
            clr  = (d_ack && d_ack_id == 5'(k)) || (acc && d_pwr && d_addr == 4'd8 && d_wdata[k]);
            m_pend[k] = set || (m_pend[k] && !clr);
        end
        m_pend[LINE] = (m_fifo.size() > 0);
        if (acc && d_pwr && d_addr == 4'd0) m_mask = d_wdata;
        m_prev  = d_ev;
        m_first = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = d_rst; events = d_ev; fv = d_fv; fd = d_fd; ack = d_ack; ack_id = d_ack_id;
        apb_bus.psel = d_psel; apb_bus.penable = d_pen; apb_bus.pwrite = d_pwr;
        apb_bus.paddr = d_addr; apb_bus.pwdata = d_wdata;
        model_step();
        d_fv = 1'b0; d_ack = 1'b0; d_psel = 1'b0; d_pen = 1'b0;
    endtask

    task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] data);
        d_psel = 1'b1; d_pen = 1'b0; d_pwr = wr; d_addr = addr; d_wdata = data;
        tick();
        d_psel = 1'b1; d_pen = 1'b1; d_pwr = wr; d_addr = addr; d_wdata = data;
        tick();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: the DUT presents its outputs every cycle, so one expected entry is popped and compared per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("irq_req", 32'(irq_req), 32'(mon_e.req));
                check("irq_id", 32'(irq_id), 32'(mon_e.id));
                check("irq_x", irq_x, mon_e.x);
                check("fulln", 32'(fulln), 32'(mon_e.fulln));
                check("pready", 32'(apb_bus.pready), 32'd1);
                check("pslverr", 32'(apb_bus.pslverr), 32'(mon_e.pslverr));
                check("prdata", apb_bus.prdata, mon_e.prdata);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bit apb_setup;
        rst = 1'b1; events = '0; fv = 1'b0; fd = '0; ack = 1'b0; ack_id = '0;
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
        apb_bus.paddr = '0; apb_bus.pwdata = '0;

        // Reset while line 11 is held high. That level must not count as an edge afterwards.
        d_rst = 1'b1; d_ev = 32'h0000_0800;
        ticks(2);
        d_rst = 1'b0;
        ticks(2);
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_fulln", 32'(fulln), 32'd1);
        check("rst_x", irq_x, 32'd0);
        apb(1'b1, 4'h0, 32'hFFFF_FFFF);
        ticks(2);
        check("rst_level_no_edge", 32'(irq_req), 32'd0);
        apb(1'b0, 4'h4, 32'd0);
        d_ev = '0;
        tick();

        // Single pulse on line 5, then ack.
        d_ev[5] = 1'b1; tick();
        d_ev[5] = 1'b0; ticks(2);
        check("req5_lat", 32'(irq_req), 32'd1);
        check("id5", 32'(irq_id), 32'd5);
        d_ack = 1'b1; d_ack_id = 5'd5; tick();
        tick();
        check("ack5_still_req", 32'(irq_req), 32'd1);
        tick();
        check("ack5_drop", 32'(irq_req), 32'd0);

        // Lines 3 and 9 together: fixed priority.
        d_ev = (32'd1 << 3) | (32'd1 << 9); tick();
        d_ev = '0; ticks(2);
        check("prio_id3", 32'(irq_id), 32'd3);
        d_ack = 1'b1; d_ack_id = 5'd3; ticks(3);
        check("prio_id9", 32'(irq_id), 32'd9);
        check("prio_req9", 32'(irq_req), 32'd1);
        d_ack = 1'b1; d_ack_id = 5'd9; ticks(3);

        // FIFO: fill, overflow drop, drain, and the FIFO line falls after the last pop.
        for (int i = 0; i < 5; i++) begin
            d_fv = 1'b1; d_fd = 8'(8'hA0 + i); tick();
        end
        check("fifo_full", 32'(fulln), 32'd0);
        ticks(2);
        check("fifo_irq_id", 32'(irq_id), 32'(LINE));
        for (int i = 0; i < 5; i++) apb(1'b0, 4'hC, 32'd0);
        check("fifo_irq_fall", 32'(irq_req), 32'd0);

        // Masked line 7 stays pending without a request, then unmasking presents it.
        apb(1'b1, 4'h0, 32'hFFFF_FF7F);
        d_ev[7] = 1'b1; tick();
        d_ev[7] = 1'b0; ticks(3);
        check("masked_no_req", 32'(irq_req), 32'd0);
        apb(1'b0, 4'h4, 32'd0);
        apb(1'b1, 4'h0, 32'hFFFF_FFFF);
        ticks(2);
        check("unmask_id7", 32'(irq_id), 32'd7);
        d_ack = 1'b1; d_ack_id = 5'd7; ticks(3);

        // An ack coinciding with a new edge on the same line: set wins.
        d_ev[4] = 1'b1; tick();
        d_ev[4] = 1'b0; ticks(2);
        check("id4", 32'(irq_id), 32'd4);
        d_ev[4] = 1'b1; d_ack = 1'b1; d_ack_id = 5'd4; tick();
        ticks(2);
        check("ack_edge_req", 32'(irq_req), 32'd1);
        check("ack_edge_id", 32'(irq_id), 32'd4);
        d_ev = '0;
        d_ack = 1'b1; d_ack_id = 5'd4; ticks(3);
        check("ack4_drop", 32'(irq_req), 32'd0);

        // A CLEAR write coinciding with a new edge on line 4: set wins.
        d_ev[4] = 1'b1; tick();
        d_ev[4] = 1'b0; tick();
        d_psel = 1'b1; d_pen = 1'b0; d_pwr = 1'b1; d_addr = 4'h8; d_wdata = 32'h10; tick();
        d_psel = 1'b1; d_pen = 1'b1; d_ev[4] = 1'b1; tick();
        d_ev = '0;
        apb(1'b0, 4'h4, 32'd0);
        apb(1'b1, 4'h8, 32'h10);

        // A push and a pop in the same cycle at full: both happen.
        for (int i = 0; i < 4; i++) begin
            d_fv = 1'b1; d_fd = 8'(8'h10 + i); tick();
        end
        d_psel = 1'b1; d_pen = 1'b0; d_pwr = 1'b0; d_addr = 4'hC; tick();
        d_psel = 1'b1; d_pen = 1'b1; d_fv = 1'b1; d_fd = 8'h55; tick();
        tick();
        check("fifo_push_pop_full", 32'(fulln), 32'd0);
        for (int i = 0; i < 5; i++) apb(1'b0, 4'hC, 32'd0);

        // Reset mid-operation with FIFO entries and pending lines.
        d_fv = 1'b1; d_fd = 8'h77; tick();
        d_fv = 1'b1; d_fd = 8'h78; tick();
        d_ev = 32'h0000_000E; tick();
        d_ev = '0; ticks(2);
        d_rst = 1'b1; tick();
        d_rst = 1'b0; tick();
        check("midrst_req", 32'(irq_req), 32'd0);
        check("midrst_fulln", 32'(fulln), 32'd1);
        check("midrst_x", irq_x, 32'd0);
        apb(1'b0, 4'hC, 32'd0);
        apb(1'b0, 4'h4, 32'd0);

        // Randomised traffic.
        apb_setup = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            d_rst = ($urandom_range(0, 499) == 0);
            d_ev  = d_ev ^ ($urandom & $urandom & $urandom & $urandom);
            d_fv  = ($urandom_range(0, 3) == 0);
            d_fd  = 8'($urandom);
            if (m_req && $urandom_range(0, 2) == 0) begin
                d_ack = 1'b1; d_ack_id = 5'(m_id);
            end else if ($urandom_range(0, 9) == 0) begin
                d_ack = 1'b1; d_ack_id = 5'($urandom);
            end
            if (apb_setup) begin
                d_psel = 1'b1; d_pen = 1'b1; apb_setup = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                d_psel  = 1'b1; d_pen = 1'b0; d_pwr = 1'($urandom);
                d_addr  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : {2'($urandom), 2'b00};
                d_wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
                apb_setup = 1'b1;
            end
            tick();
        end
        d_rst = 1'b0; d_ev = '0;
        ticks(2);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
